// File: rtl/riscv_pkg.sv
// Shared riscv32i types and constants used by the fetch front end.
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t RESET_PC = 32'h0000_0000;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries with a registered head
// that keeps showing the last entry once the FIFO drains.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          do_pop;
  logic          empty_after_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    do_pop          = pop && (count != '0);
    rd_nxt          = do_pop ? ptr_inc(rd_ptr) : rd_ptr;
    cnt_nxt         = count + CW'(push) - CW'(do_pop);
    empty_after_pop = ((count - CW'(do_pop)) == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      rd_ptr <= rd_nxt;
      count  <= cnt_nxt;
      // A push into an (effectively) empty FIFO becomes the head directly,
      // since its slot is only being written this cycle.
      if (push && empty_after_pop) begin
        head <= push_data;
      end else if (cnt_nxt != '0) begin
        head <= mem[rd_nxt];
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// riscv32i fetch front end: PC register, sequential word fetch from a
// synchronous instruction memory, output buffering and redirect flush.
module fetch_stage #(
  parameter int                 XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]    RESET_PC  = riscv_pkg::RESET_PC,
  parameter int                 BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic            misalign_err
);

  import riscv_pkg::*;

  localparam int CW = $clog2(BUF_DEPTH+1);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic            pop;
  logic            push;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

  // Issue looks at occupancy after this cycle's pop, so out_ready reaches
  // imem_req combinationally and full throughput holds with two entries.
  always_comb begin
    out_valid = (count != '0);
    pop       = out_valid && out_ready;
    occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    imem_req  = !rst && !redirect_valid && (occupancy < (CW+1)'(BUF_DEPTH));
    imem_addr = pc;
    push      = inflight && !rst && !redirect_valid;
    push_data = '{pc: inflight_pc, instr: imem_rdata};
    out_pc    = head.pc;
    out_instr = head.instr;
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      inflight     <= 1'b0;
      inflight_pc  <= '0;
      misalign_err <= 1'b0;
    end else if (redirect_valid) begin
      pc           <= {redirect_pc[XLEN-1:2], 2'b00};
      inflight     <= 1'b0;
      misalign_err <= (redirect_pc[1:0] != 2'b00);
    end else begin
      misalign_err <= 1'b0;
      if (imem_req) begin
        inflight    <= 1'b1;
        inflight_pc <= pc;
        pc          <= pc + XLEN'(INSTR_BYTES);
      end else begin
        inflight    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, backpressure/reset sequences,
// and a randomized run against a stream-level reference model.
module tb_fetch_stage;

  localparam int          DEPTH = 2;
  localparam logic [31:0] SALT  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        misalign_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .misalign_err   (misalign_err)
  );

  // Synchronous instruction memory: data one cycle after the request.
  always @(posedge clk) imem_rdata <= imem_req ? (imem_addr ^ SALT) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic        mis;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rdy, input logic redir, input logic [31:0] rpc,
                     input logic req, input logic [31:0] addr,
                     input logic vld, input logic [31:0] pc, input logic mis);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.req = req;
    v.addr = addr; v.vld = vld; v.pc = pc; v.mis = mis;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nreq;
    int          got;
    int          outstanding;
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    logic [31:0] tgt;
    logic [31:0] held_pc;
    logic        exp_mis;
    logic        prev_redir;
    logic        held;

    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset window plus the first cycles after release (row 0 = release)
    add(1, 0, 32'h0, 1, 32'h0, 0, 32'h0, 0);
    add(1, 0, 32'h0, 1, 32'h4, 0, 32'h0, 0);
    for (int k = 2; k < 8; k++) add(1, 0, 32'h0, 1, 32'(4*k), 1, 32'(4*(k-2)), 0);
    // Redirect with one buffered entry and one fetch in flight
    add(1, 1, 32'h100, 0, 32'h0, 1, 32'h18, 0);
    add(1, 0, 32'h0, 1, 32'h100, 0, 32'h0, 0);
    add(1, 0, 32'h0, 1, 32'h104, 0, 32'h0, 0);
    add(1, 0, 32'h0, 1, 32'h108, 1, 32'h100, 0);
    add(1, 0, 32'h0, 1, 32'h10C, 1, 32'h104, 0);
    // Misaligned redirect
    add(1, 1, 32'h102, 0, 32'h0, 1, 32'h108, 0);
    add(1, 0, 32'h0, 1, 32'h100, 0, 32'h0, 1);
    add(1, 0, 32'h0, 1, 32'h104, 0, 32'h0, 0);
    add(1, 0, 32'h0, 1, 32'h108, 1, 32'h100, 0);
    add(1, 0, 32'h0, 1, 32'h10C, 1, 32'h104, 0);
    // PC wrap across the top of the address space
    add(1, 1, 32'hFFFF_FFF8, 0, 32'h0, 1, 32'h108, 0);
    add(1, 0, 32'h0, 1, 32'hFFFF_FFF8, 0, 32'h0, 0);
    add(1, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0);
    add(1, 0, 32'h0, 1, 32'h0, 1, 32'hFFFF_FFF8, 0);
    add(1, 0, 32'h0, 1, 32'h4, 1, 32'hFFFF_FFFC, 0);
    add(1, 0, 32'h0, 1, 32'h8, 1, 32'h0, 0);
    add(1, 0, 32'h0, 1, 32'hC, 1, 32'h4, 0);

    repeat (5) begin
      @(negedge clk); #1;
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_pc", out_pc, 32'h0);
      chk("rst_misalign", 32'(misalign_err), 32'h0);
    end

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = 1'b0; out_ready = tbl[i].rdy;
      redirect_valid = tbl[i].redir; redirect_pc = tbl[i].rpc;
      #1;
      chk($sformatf("tbl[%0d].req", i), 32'(imem_req), 32'(tbl[i].req));
      if (tbl[i].req) chk($sformatf("tbl[%0d].addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl[%0d].valid", i), 32'(out_valid), 32'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk($sformatf("tbl[%0d].pc", i), out_pc, tbl[i].pc);
        chk($sformatf("tbl[%0d].instr", i), out_instr, tbl[i].pc ^ SALT);
      end
      chk($sformatf("tbl[%0d].misalign", i), 32'(misalign_err), 32'(tbl[i].mis));
    end

    // Mid-stream reset, then release into backpressure
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; #1;
    chk("midrst_req", 32'(imem_req), 32'h0);
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b0; #1;
      if (imem_req) begin
        if (nreq < 2) chk("bp_addr", imem_addr, 32'(nreq*4));
        nreq++;
      end
      if (i >= 2) begin
        chk("bp_valid", 32'(out_valid), 32'h1);
        chk("bp_pc", out_pc, 32'h0);
        chk("bp_instr", out_instr, SALT);
      end else begin
        chk("bp_early_valid", 32'(out_valid), 32'h0);
      end
    end
    chk("bp_nreq", 32'(nreq), 32'h2);
    got = 0;
    for (int i = 0; i < 10 && got < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b1; #1;
      if (out_valid) begin
        chk("bp_drain_pc", out_pc, 32'(got*4));
        chk("bp_drain_instr", out_instr, 32'(got*4) ^ SALT);
        got++;
      end
    end
    chk("bp_drain_count", 32'(got), 32'h3);

    // Randomized run: delivered stream and fetch addresses are each a
    // consecutive word sequence starting at the last redirect target.
    exp_pc = '0; exp_fetch = '0; outstanding = 0;
    exp_mis = 1'b0; prev_redir = 1'b0; held = 1'b0; held_pc = '0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = (c == 0) || ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 4) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else                           redirect_pc = $urandom;
      #1;
      chk("rand_misalign", 32'(misalign_err), 32'(exp_mis));
      if (prev_redir) chk("rand_flush_valid", 32'(out_valid), 32'h0);
      if (held) begin
        chk("rand_hold_valid", 32'(out_valid), 32'h1);
        chk("rand_hold_pc", out_pc, held_pc);
      end
      if (redirect_valid) chk("rand_redir_req", 32'(imem_req), 32'h0);
      else if (imem_req) chk("rand_addr", imem_addr, exp_fetch);
      if (out_valid && out_ready && !redirect_valid) begin
        chk("rand_pc", out_pc, exp_pc);
        chk("rand_instr", out_instr, exp_pc ^ SALT);
        exp_pc = exp_pc + 32'd4;
        outstanding--;
      end
      if (imem_req) begin
        exp_fetch = exp_fetch + 32'd4;
        outstanding++;
      end
      if (redirect_valid) begin
        tgt = {redirect_pc[31:2], 2'b00};
        exp_pc = tgt; exp_fetch = tgt; outstanding = 0;
      end
      chk("rand_occupancy", 32'(outstanding <= DEPTH), 32'h1);
      exp_mis    = redirect_valid && (redirect_pc[1:0] != 2'b00);
      held       = out_valid && !out_ready && !redirect_valid;
      held_pc    = out_pc;
      prev_redir = redirect_valid;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
